div_result_bcd: RTL and testbench
=================================

Name: div_result_bcd

Overview:
- Sequential binary-to-BCD converter, directly downstream of the repeated-subtraction divider.
- Captures the divider's 8-bit Quotient and Remainder on a `convert` pulse.
- Converts both values in parallel using a double-dabble shift/add-3 loop.
- Holds the packed BCD digits stable for the display/readout stage, with a one-cycle done strobe.

Parameters:
- WIDTH, 8, bit width of the Quotient and Remainder inputs.
- DIGITS, 3, BCD digits per output. Must satisfy 10^DIGITS > 2^WIDTH-1. Not checked in RTL.
- CW, 4, width of the internal iteration counter. Must satisfy 2^CW > WIDTH.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- Clear  input  1  asynchronous, active-high reset.
- convert  input  1  request to sample Quotient/Remainder. Accepted only when busy=0.
- Quotient  input  WIDTH  binary quotient from the divider.
- Remainder  input  WIDTH  binary remainder from the divider.
- q_bcd  output  4*DIGITS  packed BCD of the captured quotient; MS digit in the top nibble.
- r_bcd  output  4*DIGITS  packed BCD of the captured remainder.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle strobe; q_bcd/r_bcd are valid and new on this cycle.

Behaviour:
- Interface decided: single clock clk; reset Clear is asynchronous and active-high.
- Reset values while Clear=1: state=IDLE, cnt=0, shift registers 0, q_bcd=0, r_bcd=0, busy=0, done=0.
- FSM states: IDLE, SHIFT. Two-bit encoding comes from the package.
- IDLE:
  - If convert=1 at edge E0, load bin_q<=Quotient, bin_r<=Remainder, clear both BCD accumulators, cnt<=0, state<=SHIFT.
  - Otherwise hold.
- SHIFT, each edge:
  - For each accumulator, add 3 to every nibble >=5 (combinational, pre-shift).
  - Then shift {bcd, bin} left by 1.
  - cnt<=cnt+1.
- At edge E_WIDTH (cnt==WIDTH-1 before the edge):
  - Perform the final step.
  - Register the results into q_bcd/r_bcd.
  - done<=1, state<=IDLE.
- Latency: done is high during the cycle after edge E0+WIDTH (8 shift cycles plus 1 load cycle for defaults).
- busy = (state==SHIFT); combinational decode of a registered state.
- done is registered and cleared on the next edge; never high for two consecutive cycles.
- q_bcd/r_bcd change only on the done-producing edge. They hold their value between conversions and during a new conversion.
- convert while busy=1 is ignored and not queued. This includes a convert sampled at the same edge as E_WIDTH.
- Back-to-back: convert=1 during the done cycle (state IDLE) is accepted. The next done follows exactly WIDTH+1 cycles later.
- Quotient/Remainder are sampled only at E0; later input changes have no effect on the running conversion.
- Clear mid-conversion:
  - Immediate return to the reset values above.
  - No done is produced for the aborted conversion.
  - Previously held outputs are lost (zeroed).
- Arithmetic:
  - Each add-3 is a 4-bit nibble add, no carry out. A corrected nibble <=12 cannot overflow.
  - The accumulator is 4*DIGITS bits; bits shifted out of its top are discarded. This is legal only under the parameter constraint.

Decomposition:
- Shared package div_pkg:
  - FSM state localparams (ST_IDLE, ST_SHIFT).
  - Default WIDTH/DIGITS constants.
  - Helper function nibble_fix(nib) returning nib+3 when nib>=5.
- Sub-module dd_step:
  - Combinational, parameterised by DIGITS.
  - Inputs: bcd, bin MSB. Output: next bcd (corrections applied, then shifted with the bin MSB shifted in).
  - Instantiated twice, once for the quotient path and once for the remainder path.
- The top level holds the FSM, counter, bin shift registers and output registers.

Test Plan:
- Reset then idle: Clear pulse, no convert for 20 cycles -> q_bcd=0, r_bcd=0, busy=0, done never asserted.
- Typical result: Quotient=28, Remainder=4 (200/7) -> busy for 8 cycles; done one cycle at E0+9; q_bcd=12'h028, r_bcd=12'h004.
- Extremes: Quotient=255, Remainder=0 -> 12'h255/12'h000; then Quotient=0, Remainder=255 -> 12'h000/12'h255; also 9->12'h009, 10->12'h010, 99->12'h099, 100->12'h100.
- Busy collision and back-to-back:
  - Convert (Q=50) followed by convert (Q=77) during SHIFT -> second ignored, output 12'h050.
  - Convert (Q=77) held in the done cycle -> accepted; 12'h077 exactly 9 cycles later.
- Input hold: change Quotient from 28 to 200 on the cycle after E0 -> result still 12'h028.
- Reset mid-op:
  - Assert Clear at cycle 4 of a conversion of Q=123 -> outputs 0, busy=0 asynchronously, no done.
  - A subsequent convert of Q=123 -> 12'h123.

Source files
------------

// File: rtl/div_result_bcd_pkg.sv
// Shared definitions for the divider-result BCD converter: FSM encoding,
// default sizes and the double-dabble nibble correction.
package div_result_bcd_pkg;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_DIGITS = 3;
  localparam int DEF_CW     = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1
  } state_t;

  // Pre-shift correction so a nibble >= 5 carries into the next digit after doubling.
  function automatic logic [3:0] nibble_fix(input logic [3:0] nib);
    logic [3:0] res;
    if (nib >= 4'd5) begin
      res = nib + 4'd3;
    end else begin
      res = nib;
    end
    return res;
  endfunction

endpackage

// File: rtl/div_result_bcd_if.sv
// Request/result bundle between the divider side and the BCD converter.
interface div_result_bcd_if
  import div_result_bcd_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DIGITS = DEF_DIGITS
);
  logic                  convert;
  logic [WIDTH-1:0]      Quotient;
  logic [WIDTH-1:0]      Remainder;
  logic [4*DIGITS-1:0]   q_bcd;
  logic [4*DIGITS-1:0]   r_bcd;
  logic                  busy;
  logic                  done;

  modport master (
    output convert, Quotient, Remainder,
    input  q_bcd, r_bcd, busy, done
  );

  modport slave (
    input  convert, Quotient, Remainder,
    output q_bcd, r_bcd, busy, done
  );
endinterface

// File: rtl/div_result_bcd_dd_step.sv
// One combinational double-dabble iteration: correct every nibble, then
// shift the accumulator left taking in the next binary MSB.
module div_result_bcd_dd_step
  import div_result_bcd_pkg::*;
#(
  parameter int DIGITS = DEF_DIGITS
) (
  input  logic [4*DIGITS-1:0] i_bcd,
  input  logic                i_bin_msb,
  output logic [4*DIGITS-1:0] o_bcd
);

  logic [4*DIGITS-1:0] w_fixed;
  logic                w_unused_top;

  always_comb begin
    w_fixed = '0;
    for (int d = 0; d < DIGITS; d++) begin
      w_fixed[4*d +: 4] = nibble_fix(i_bcd[4*d +: 4]);
    end
  end

  // The bit shifted out of the top is discarded; the digit count guarantees it is zero.
  assign {w_unused_top, o_bcd} = {w_fixed, i_bin_msb};

endmodule

// File: rtl/div_result_bcd.sv
// Sequential binary-to-BCD converter for the divider's quotient and remainder,
// both paths converted in lockstep, results held until the next conversion.
module div_result_bcd
  import div_result_bcd_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DIGITS = DEF_DIGITS,
  parameter int CW     = DEF_CW
) (
  input  logic             clk,
  input  logic             Clear,
  div_result_bcd_if.slave  bus
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_load;
  logic                w_last;
  logic [CW-1:0]       r_cnt;
  logic [WIDTH-1:0]    r_bin_q;
  logic [WIDTH-1:0]    r_bin_r;
  logic [4*DIGITS-1:0] r_acc_q;
  logic [4*DIGITS-1:0] r_acc_r;
  logic [4*DIGITS-1:0] w_acc_q_nxt;
  logic [4*DIGITS-1:0] w_acc_r_nxt;
  logic [4*DIGITS-1:0] r_q_bcd;
  logic [4*DIGITS-1:0] r_r_bcd;
  logic                r_done;

  div_result_bcd_dd_step #(.DIGITS(DIGITS)) u_step_q (
    .i_bcd     (r_acc_q),
    .i_bin_msb (r_bin_q[WIDTH-1]),
    .o_bcd     (w_acc_q_nxt)
  );

  div_result_bcd_dd_step #(.DIGITS(DIGITS)) u_step_r (
    .i_bcd     (r_acc_r),
    .i_bin_msb (r_bin_r[WIDTH-1]),
    .o_bcd     (w_acc_r_nxt)
  );

  // Convert is only honoured from IDLE, so a request during SHIFT is dropped.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.convert) begin
          w_state_nxt = ST_SHIFT;
          w_load      = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (r_cnt == CW'(WIDTH - 1)) begin
          w_state_nxt = ST_IDLE;
          w_last      = 1'b1;
        end else begin
          w_state_nxt = ST_SHIFT;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge Clear) begin
    if (Clear) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_bin_q <= '0;
      r_bin_r <= '0;
      r_acc_q <= '0;
      r_acc_r <= '0;
      r_q_bcd <= '0;
      r_r_bcd <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_last;
      if (w_load) begin
        r_bin_q <= bus.Quotient;
        r_bin_r <= bus.Remainder;
        r_acc_q <= '0;
        r_acc_r <= '0;
        r_cnt   <= '0;
      end else if (r_state == ST_SHIFT) begin
        r_bin_q <= {r_bin_q[WIDTH-2:0], 1'b0};
        r_bin_r <= {r_bin_r[WIDTH-2:0], 1'b0};
        r_acc_q <= w_acc_q_nxt;
        r_acc_r <= w_acc_r_nxt;
        r_cnt   <= r_cnt + CW'(1);
        // Outputs update only on the final step; they stay put during a new run.
        if (w_last) begin
          r_q_bcd <= w_acc_q_nxt;
          r_r_bcd <= w_acc_r_nxt;
        end
      end
    end
  end

  assign bus.q_bcd = r_q_bcd;
  assign bus.r_bcd = r_r_bcd;
  assign bus.busy  = (r_state == ST_SHIFT);
  assign bus.done  = r_done;

endmodule

// File: tb/tb_div_result_bcd.sv
// Randomised scoreboard bench for div_result_bcd with an arithmetic BCD reference.
module tb_div_result_bcd;

  localparam int WIDTH  = 8;
  localparam int DIGITS = 3;

  typedef struct {
    logic [11:0] q;
    logic [11:0] r;
    int          done_edge;
  } exp_t;

  logic clk;
  logic Clear;
  int   cyc;
  int   free_edge;
  int   n_checks;
  int   n_fail;
  bit   end_check;
  exp_t sb[$];

  div_result_bcd_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

  div_result_bcd #(.WIDTH(WIDTH), .DIGITS(DIGITS), .CW(4)) dut (
    .clk   (clk),
    .Clear (Clear),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [11:0] to_bcd(input int v);
    return 12'(((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + (v % 10));
  endfunction

  function automatic void chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endfunction

  // Convert request sampled at the next edge; the model decides acceptance.
  task automatic issue(input int q, input int r);
    int k;
    bus.convert   = 1'b1;
    bus.Quotient  = 8'(q);
    bus.Remainder = 8'(r);
    k = cyc + 1;
    if (k >= free_edge) begin
      exp_t e;
      e.q = to_bcd(q);
      e.r = to_bcd(r);
      e.done_edge = k + WIDTH;
      sb.push_back(e);
      free_edge = k + WIDTH + 1;
    end
    @(posedge clk); #1;
    bus.convert = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_clear();
    Clear = 1'b1;
    free_edge = -100;
    @(posedge clk); #1;
    Clear = 1'b0;
  endtask

  // Monitor: compares every cycle against the scoreboard and the model's busy window.
  initial begin : monitor
    logic [11:0] last_q;
    logic [11:0] last_r;
    bit          end_done;
    bit          exp_done;
    bit          exp_busy;
    exp_t        e;
    last_q = 12'd0;
    last_r = 12'd0;
    end_done = 1'b0;
    forever begin
      @(negedge clk);
      if (Clear) begin
        sb.delete();
        last_q = 12'd0;
        last_r = 12'd0;
        chk("rst_q_bcd", int'(bus.q_bcd), 0);
        chk("rst_r_bcd", int'(bus.r_bcd), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
      end else begin
        exp_done = (sb.size() > 0) && (sb[0].done_edge == cyc);
        exp_busy = (cyc >= free_edge - WIDTH - 1) && (cyc <= free_edge - 2);
        chk("done", int'(bus.done), int'(exp_done));
        chk("busy", int'(bus.busy), int'(exp_busy));
        if (exp_done) begin
          e = sb.pop_front();
          last_q = e.q;
          last_r = e.r;
        end
        chk("q_bcd", int'(bus.q_bcd), int'(last_q));
        chk("r_bcd", int'(bus.r_bcd), int'(last_r));
        if (end_check && !end_done) begin
          end_done = 1'b1;
          chk("drain_pending", sb.size(), 0);
        end
      end
    end
  end

  initial begin : driver
    int gap;
    int budget;
    cyc = 0;
    n_checks = 0;
    n_fail = 0;
    end_check = 1'b0;
    free_edge = -100;
    Clear = 1'b1;
    bus.convert = 1'b0;
    bus.Quotient = 8'd0;
    bus.Remainder = 8'd0;
    repeat (2) @(posedge clk);
    #1 Clear = 1'b0;
    idle(20);

    issue(28, 4);   idle(12);
    issue(255, 0);  idle(12);
    issue(0, 255);  idle(12);
    issue(9, 10);   idle(12);
    issue(99, 100); idle(12);

    // Second request during SHIFT is dropped; one held over E8/E9 lands on E9.
    issue(50, 3);
    idle(3);
    issue(77, 1);
    while (cyc < free_edge - 2) idle(1);
    issue(77, 5);
    issue(77, 5);
    idle(12);

    // Inputs move after capture; the running conversion must not see it.
    issue(28, 6);
    bus.Quotient = 8'd200;
    bus.Remainder = 8'd201;
    idle(12);

    issue(123, 45);
    idle(3);
    do_clear();
    idle(12);
    issue(123, 45);
    idle(12);

    for (int i = 0; i < 30; i++) begin
      issue(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
      gap = int'($urandom_range(0, 11));
      idle(gap);
    end

    budget = 40;
    while (sb.size() > 0 && budget > 0) begin
      idle(1);
      budget--;
    end
    end_check = 1'b1;
    idle(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
